// File: rtl/daq_uart_tx.sv
// Byte-serial UART transmitter fed by the DAQ RAM readout stage.
// Holds tx_data_loaded for the whole frame so upstream advances once per byte.
module daq_uart_tx #(
  parameter int CLKS_PER_BIT = 347,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       tx_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_data_ready,
  output logic       tx_data_loaded,
  output logic       busy,
  output logic       uart_txd
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP,
    GAP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_cnt;
  logic             r_stop_cnt;
  logic [7:0]       r_shift;
  logic             r_par;
  logic             r_loaded;
  logic             r_busy;
  logic             r_txd;
  logic             w_bit_end;

  // Odd: data plus parity has an odd count of ones; even: an even count.
  function automatic logic parity_of(input logic [7:0] d);
    if (PARITY == 1) return ~(^d);
    return ^d;
  endfunction

  assign w_bit_end      = (r_baud_cnt == CNT_LAST);
  assign tx_data_loaded = r_loaded;
  assign busy           = r_busy;
  assign uart_txd       = r_txd;

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_loaded   <= 1'b0;
      r_busy     <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_data_ready) begin
            r_shift    <= tx_data;
            r_par      <= parity_of(tx_data);
            r_loaded   <= 1'b1;
            r_busy     <= 1'b1;
            r_txd      <= 1'b0;
            r_baud_cnt <= '0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_txd      <= r_shift[0];
            r_state    <= DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            // 3-bit counter wraps 7 -> 0 as the last data bit ends.
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (PARITY != 0) begin
                r_txd   <= r_par;
                r_state <= PARITY_BIT;
              end else begin
                r_txd      <= 1'b1;
                r_stop_cnt <= 1'b0;
                r_state    <= STOP;
              end
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        PARITY_BIT: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_txd      <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_stop_cnt == STOP_LAST) begin
              r_loaded <= 1'b0;
              r_state  <= GAP;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        GAP: begin
          // One cycle with loaded low guarantees the upstream sync sees it drop.
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/daq_uart_tx.md
# daq_uart_tx

Byte-serial UART transmitter that sits directly downstream of the DAQ RAM readout stage in the tx_clk domain. It accepts one byte per tx_data_ready / tx_data_loaded handshake and shifts it out LSB-first on a single asynchronous serial line. It holds tx_data_loaded high for the entire frame, so the upstream stage advances its address exactly once per byte and waits for frame completion before offering the next.

## Interface
- CLKS_PER_BIT, 347, tx_clk cycles per serial bit (40 MHz / 115200); legal range 2..65535.
- PARITY, 0, 0 = none, 1 = odd, 2 = even; other values are illegal.
- STOP_BITS, 1, number of stop bits, 1 or 2.

- tx_clk  input  1  sole clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the tx_clk rising edge.
- tx_data  input  8  byte to send; sampled only on the acceptance edge.
- tx_data_ready  input  1  upstream has a byte available.
- tx_data_loaded  output  1  high from acceptance until the end of the last stop bit.
- busy  output  1  high in every state except IDLE.
- uart_txd  output  1  serial line; idles at 1.

## Operation
- States: IDLE, START, DATA, PARITY_BIT, STOP, GAP.
- Reset values: uart_txd=1, tx_data_loaded=0, busy=0, state=IDLE, baud and bit counters=0. Reset overrides everything. Reset mid-frame returns uart_txd to 1 on the same edge and drops tx_data_loaded.
- IDLE with tx_data_ready=1 (the acceptance edge):
  - latch tx_data into the shift register;
  - compute the parity bit: odd means total ones in data plus parity is odd; even means that total is even;
  - set tx_data_loaded=1 and busy=1;
  - drive uart_txd=0 and go to START.
- Each of START, DATA (×8), PARITY_BIT and STOP (×STOP_BITS) lasts exactly CLKS_PER_BIT cycles.
- The baud counter counts 0..CLKS_PER_BIT-1 and clears on every bit boundary. Its width is the minimum needed to hold CLKS_PER_BIT-1.
- DATA shifts right; uart_txd = shift_reg[0]. The 3-bit bit counter wraps 7 -> 0 on leaving DATA.
- PARITY_BIT is skipped when PARITY=0. STOP drives uart_txd=1.
- End of the last stop bit: tx_data_loaded=0, go to GAP for exactly 1 cycle (busy=1), then go to IDLE.
- tx_data_ready is ignored outside IDLE. Changes to tx_data mid-frame do not affect the frame in flight.
- If tx_data_ready is still high on reaching IDLE, a new frame is accepted that cycle. Back-to-back frames are therefore separated by one GAP cycle plus one IDLE cycle of line-high idle, on top of the stop bits.

## Timing
- Acceptance latency: tx_data_loaded and the start-bit falling edge both appear on the edge after the first IDLE cycle with tx_data_ready=1.
- Frame length N = (1 + 8 + (PARITY!=0) + STOP_BITS) × CLKS_PER_BIT cycles. tx_data_loaded is high for exactly N cycles.
- Data bit k (k=0..7) is driven during cycles [(1+k)×CLKS_PER_BIT, (2+k)×CLKS_PER_BIT) after acceptance.
- uart_txd is registered: no combinational path from any input.
- tx_data_loaded is registered and glitch-free, so the upstream 2-flop synchroniser sees a clean level.
- Upstream contract: ready is dropped within a few cycles of seeing loaded, and is not re-raised until loaded has been seen low. The GAP cycle keeps loaded low for at least 2 cycles before any re-acceptance.

## Test plan
- Reset: assert reset for 3 cycles with tx_data_ready=1 -> uart_txd=1, tx_data_loaded=0, busy=0 throughout. First acceptance occurs on the edge after reset deasserts.
- Single byte, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1: tx_data=0xA5 -> line bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_data_loaded high for exactly 40 cycles; busy high for 41 cycles.
- Parity, CLKS_PER_BIT=4, STOP_BITS=2, tx_data=0x81:
  - PARITY=2 -> parity bit 0, frame 48 cycles;
  - PARITY=1 -> parity bit 1;
  - both stop bits high for 8 cycles in total.
- Handshake with the DAQ RAM model (2-flop loaded sync, 8 bytes 0x80..0x87) -> decoded stream is 0x80..0x87 in order. There are no duplicates or drops, and the upstream tx_complete fires after the 8th frame.
- Mid-frame: change tx_data and pulse tx_data_ready during DATA -> the transmitted byte is unchanged. Assert reset at bit 3 -> line is high next edge, loaded=0, and the next frame is sent cleanly.
- Continuous tx_data_ready=1, CLKS_PER_BIT=2 -> frames are 2 cycles of line-high apart between the end of stop and the next start bit; the baud counter never exceeds 1.
